multiport_register_file: RTL and testbench

MULTIPORT_REGISTER_FILE -- requirements
Module: multiport_register_file

---
 rtl/instruction_set_pkg.sv | 12 +
 rtl/rf_read_bypass.sv | 42 ++++
 rtl/multiport_register_file.sv | 135 +++++++++++++
 tb/tb_multiport_register_file.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_set_pkg.sv
// Shared machine-wide constants and types for the instruction set datapath.
// Holds the data word size and the register-file clear sequencer state type.
package instruction_set;

    localparam int WORD_SIZE = 16;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        CLEARING = 1'b1
    } rf_clear_state_t;

endpackage

// File: rtl/rf_read_bypass.sv
// One read port: stored word, overridden by same-cycle write data (port 1 wins),
// with register 0 optionally hardwired to zero.
module rf_read_bypass #(
    parameter int WORD_SIZE = 16,
    parameter int NUM_REGS  = 8,
    parameter int ZERO_REG  = 0,
    parameter int AW        = $clog2(NUM_REGS)
) (
    input  logic [AW-1:0]        read_addr,
    input  logic [WORD_SIZE-1:0] regs [NUM_REGS],
    input  logic                 write_enable_0,
    input  logic [AW-1:0]        write_addr_0,
    input  logic [WORD_SIZE-1:0] write_data_0,
    input  logic                 write_enable_1,
    input  logic [AW-1:0]        write_addr_1,
    input  logic [WORD_SIZE-1:0] write_data_1,
    output logic [WORD_SIZE-1:0] read_data
);

    logic hit_0;
    logic hit_1;
    logic zero_hit;

    assign hit_0    = write_enable_0 && (write_addr_0 == read_addr);
    assign hit_1    = write_enable_1 && (write_addr_1 == read_addr);
    assign zero_hit = (ZERO_REG != 0) && (read_addr == '0);

    // Later assignments take priority: port 1 over port 0, zero mask over everything.
    always_comb begin
        read_data = regs[read_addr];
        if (hit_0) begin
            read_data = write_data_0;
        end
        if (hit_1) begin
            read_data = write_data_1;
        end
        if (zero_hit) begin
            read_data = '0;
        end
    end

endmodule

// File: rtl/multiport_register_file.sv
// Flip-flop register file: two combinational read ports with write-through bypass,
// two write ports (port 1 wins on collision) and a one-register-per-cycle clear sweep.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | normal operation, writes commit, clear_req starts a sweep
// CLEARING | zero register[sweep_cnt] each cycle, writes/clear_req ignored
module multiport_register_file #(
    parameter int WORD_SIZE = instruction_set::WORD_SIZE,
    parameter int NUM_REGS  = 8,
    parameter int ZERO_REG  = 0,
    parameter int AW        = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [AW-1:0]        read_addr_a,
    input  logic [AW-1:0]        read_addr_b,
    output logic [WORD_SIZE-1:0] read_data_a,
    output logic [WORD_SIZE-1:0] read_data_b,
    input  logic [AW-1:0]        write_addr_0,
    input  logic [AW-1:0]        write_addr_1,
    input  logic [WORD_SIZE-1:0] write_data_0,
    input  logic [WORD_SIZE-1:0] write_data_1,
    input  logic                 write_enable_0,
    input  logic                 write_enable_1,
    input  logic                 clear_req,
    output logic                 busy
);

    import instruction_set::*;

    rf_clear_state_t      state;
    rf_clear_state_t      state_next;
    logic [AW-1:0]        sweep_cnt;
    logic                 sweep_last;
    logic [WORD_SIZE-1:0] regs [NUM_REGS];
    logic                 we_0_eff;
    logic                 we_1_eff;

    assign sweep_last = (sweep_cnt == AW'(NUM_REGS - 1));

    // Writes are suppressed while sweeping and never land on a hardwired-zero register 0.
    assign we_0_eff = write_enable_0 && !busy && !((ZERO_REG != 0) && (write_addr_0 == '0));
    assign we_1_eff = write_enable_1 && !busy && !((ZERO_REG != 0) && (write_addr_1 == '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_next = CLEARING;
                end
            end
            CLEARING: begin
                if (sweep_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CLEARING);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sweep_cnt <= '0;
        end else if (busy) begin
            sweep_cnt <= sweep_last ? '0 : sweep_cnt + AW'(1);
        end
    end

    // Port 1 is applied after port 0 so it owns the register on an address collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (busy) begin
            regs[sweep_cnt] <= '0;
        end else begin
            if (we_0_eff) begin
                regs[write_addr_0] <= write_data_0;
            end
            if (we_1_eff) begin
                regs[write_addr_1] <= write_data_1;
            end
        end
    end

    rf_read_bypass #(
        .WORD_SIZE (WORD_SIZE),
        .NUM_REGS  (NUM_REGS),
        .ZERO_REG  (ZERO_REG),
        .AW        (AW)
    ) u_read_a (
        .read_addr      (read_addr_a),
        .regs           (regs),
        .write_enable_0 (we_0_eff),
        .write_addr_0   (write_addr_0),
        .write_data_0   (write_data_0),
        .write_enable_1 (we_1_eff),
        .write_addr_1   (write_addr_1),
        .write_data_1   (write_data_1),
        .read_data      (read_data_a)
    );

    rf_read_bypass #(
        .WORD_SIZE (WORD_SIZE),
        .NUM_REGS  (NUM_REGS),
        .ZERO_REG  (ZERO_REG),
        .AW        (AW)
    ) u_read_b (
        .read_addr      (read_addr_b),
        .regs           (regs),
        .write_enable_0 (we_0_eff),
        .write_addr_0   (write_addr_0),
        .write_data_0   (write_data_0),
        .write_enable_1 (we_1_eff),
        .write_addr_1   (write_addr_1),
        .write_data_1   (write_data_1),
        .read_data      (read_data_b)
    );

endmodule

// File: tb/tb_multiport_register_file.sv
// Four register-file configurations run in lockstep against an array-based model;
// expectations are queued by the stimulus and compared by a negedge monitor.
module tb_multiport_register_file;

    localparam int NCFG = 4;

    function automatic int cfg_nr(int g);
        case (g)
            0:       return 8;
            1:       return 4;
            2:       return 16;
            default: return 32;
        endcase
    endfunction

    function automatic int cfg_zr(int g);
        return (g == 2) ? 1 : 0;
    endfunction

    logic        clk = 1'b0;
    logic        rst  [NCFG];
    logic [4:0]  ra   [NCFG];
    logic [4:0]  rb   [NCFG];
    logic [4:0]  wa0  [NCFG];
    logic [4:0]  wa1  [NCFG];
    logic [15:0] wd0  [NCFG];
    logic [15:0] wd1  [NCFG];
    logic        we0  [NCFG];
    logic        we1  [NCFG];
    logic        clr  [NCFG];
    logic [15:0] rda  [NCFG];
    logic [15:0] rdb  [NCFG];
    logic        bsy  [NCFG];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int NRG = cfg_nr(g);
        localparam int AWG = $clog2(NRG);
        multiport_register_file #(
            .WORD_SIZE (16),
            .NUM_REGS  (NRG),
            .ZERO_REG  (cfg_zr(g))
        ) dut (
            .clk            (clk),
            .reset          (rst[g]),
            .read_addr_a    (ra[g][AWG-1:0]),
            .read_addr_b    (rb[g][AWG-1:0]),
            .read_data_a    (rda[g]),
            .read_data_b    (rdb[g]),
            .write_addr_0   (wa0[g][AWG-1:0]),
            .write_addr_1   (wa1[g][AWG-1:0]),
            .write_data_0   (wd0[g]),
            .write_data_1   (wd1[g]),
            .write_enable_0 (we0[g]),
            .write_enable_1 (we1[g]),
            .clear_req      (clr[g]),
            .busy           (bsy[g])
        );
    end

    typedef struct {
        int          c;
        logic [15:0] ea;
        logic [15:0] eb;
        logic        ebusy;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;

    // Reference model: register contents plus number of sweep cycles still to run.
    logic [15:0] mem [NCFG][32];
    int          clear_left [NCFG];
    int          nregs [NCFG];
    bit          zr [NCFG];

    function automatic logic [15:0] model_read(int c, int a);
        if (clear_left[c] > 0) return mem[c][a];
        if (zr[c] && a == 0) return 16'h0000;
        if (we1[c] && int'(wa1[c]) == a) return wd1[c];
        if (we0[c] && int'(wa0[c]) == a) return wd0[c];
        return mem[c][a];
    endfunction

    task automatic idle_all();
        for (int c = 0; c < NCFG; c++) begin
            rst[c] = 1'b0; we0[c] = 1'b0; we1[c] = 1'b0; clr[c] = 1'b0;
            wa0[c] = '0; wa1[c] = '0; wd0[c] = '0; wd1[c] = '0;
            ra[c] = '0; rb[c] = '0;
        end
    endtask

    // Called just after a rising edge with inputs already set: queue expectations,
    // advance the model across the next edge, then wait for it.
    task automatic commit();
        for (int c = 0; c < NCFG; c++) begin
            exp_t e;
            if (rst[c]) begin
                we0[c] = 1'b0;
                we1[c] = 1'b0;
                for (int i = 0; i < 32; i++) mem[c][i] = 16'h0000;
                clear_left[c] = 0;
            end
            e.c     = c;
            e.ebusy = (clear_left[c] > 0);
            e.ea    = model_read(c, int'(ra[c]));
            e.eb    = model_read(c, int'(rb[c]));
            exp_q.push_back(e);
            if (!rst[c]) begin
                if (clear_left[c] > 0) begin
                    mem[c][nregs[c] - clear_left[c]] = 16'h0000;
                    clear_left[c]--;
                end else begin
                    if (we0[c] && !(zr[c] && wa0[c] == 0)) mem[c][wa0[c]] = wd0[c];
                    if (we1[c] && !(zr[c] && wa1[c] == 0)) mem[c][wa1[c]] = wd1[c];
                    if (clr[c]) clear_left[c] = nregs[c];
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic read_all();
        for (int i = 0; i < 32; i++) begin
            idle_all();
            for (int c = 0; c < NCFG; c++) begin
                ra[c] = 5'(i % nregs[c]);
                rb[c] = 5'((i + 1) % nregs[c]);
            end
            commit();
        end
    endtask

    task automatic fill_all();
        for (int i = 0; i < 16; i++) begin
            idle_all();
            for (int c = 0; c < NCFG; c++) begin
                if (2 * i < nregs[c]) begin
                    we0[c] = 1'b1; wa0[c] = 5'(2 * i);     wd0[c] = 16'(16'h0101 * (2 * i + 1));
                    we1[c] = 1'b1; wa1[c] = 5'(2 * i + 1); wd1[c] = 16'(16'h0101 * (2 * i + 2));
                    ra[c] = 5'(2 * i); rb[c] = 5'(2 * i + 1);
                end
            end
            commit();
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rda[e.c] !== e.ea) begin
                errors++;
                $display("FAIL read_data_a cfg%0d addr %0d: got %h want %h", e.c, ra[e.c], rda[e.c], e.ea);
            end
            checks++;
            if (rdb[e.c] !== e.eb) begin
                errors++;
                $display("FAIL read_data_b cfg%0d addr %0d: got %h want %h", e.c, rb[e.c], rdb[e.c], e.eb);
            end
            checks++;
            if (bsy[e.c] !== e.ebusy) begin
                errors++;
                $display("FAIL busy cfg%0d: got %b want %b", e.c, bsy[e.c], e.ebusy);
            end
        end
    end

    initial begin
        for (int c = 0; c < NCFG; c++) begin
            nregs[c] = cfg_nr(c);
            zr[c] = (cfg_zr(c) != 0);
            clear_left[c] = 0;
            for (int i = 0; i < 32; i++) mem[c][i] = 16'hxxxx;
        end
        idle_all();
        for (int c = 0; c < NCFG; c++) rst[c] = 1'b1;
        @(posedge clk);
        #1;
        commit();
        idle_all();
        commit();
        read_all();

        // Port 0 write to 3, bypassed in the same cycle and stored afterwards.
        idle_all();
        for (int c = 0; c < NCFG; c++) begin
            we0[c] = 1'b1; wa0[c] = 5'd3; wd0[c] = 16'h1234; ra[c] = 5'd3;
        end
        commit();
        idle_all();
        for (int c = 0; c < NCFG; c++) ra[c] = 5'd3;
        commit();

        // Both ports on one address: port 1 data wins for bypass and storage.
        idle_all();
        for (int c = 0; c < NCFG; c++) begin
            we0[c] = 1'b1; wa0[c] = 5'(5 % nregs[c]); wd0[c] = 16'hAAAA;
            we1[c] = 1'b1; wa1[c] = 5'(5 % nregs[c]); wd1[c] = 16'h5555;
            rb[c] = 5'(5 % nregs[c]);
        end
        commit();
        idle_all();
        for (int c = 0; c < NCFG; c++) rb[c] = 5'(5 % nregs[c]);
        commit();

        // Register 0 write; hardwired to zero in the ZERO_REG configuration.
        idle_all();
        for (int c = 0; c < NCFG; c++) begin
            we0[c] = 1'b1; wa0[c] = 5'd0; wd0[c] = 16'hFFFF; ra[c] = 5'd0;
        end
        commit();
        idle_all();
        commit();

        // Fill, then sweep-clear with a write in the request cycle and writes/requests while busy.
        fill_all();
        read_all();
        idle_all();
        for (int c = 0; c < NCFG; c++) begin
            clr[c] = 1'b1; we1[c] = 1'b1; wa1[c] = 5'd1; wd1[c] = 16'hC0DE; ra[c] = 5'd1;
        end
        commit();
        for (int k = 0; k < 34; k++) begin
            idle_all();
            for (int c = 0; c < NCFG; c++) begin
                if (clear_left[c] > 0) begin
                    we0[c] = 1'b1; wa0[c] = 5'($urandom_range(0, nregs[c] - 1)); wd0[c] = 16'($urandom);
                    we1[c] = 1'b1; wa1[c] = wa0[c]; wd1[c] = 16'($urandom);
                    clr[c] = (k % 3 == 0);
                    ra[c] = wa0[c]; rb[c] = 5'(k % nregs[c]);
                end
            end
            commit();
        end
        read_all();

        // Reset asserted between edges on sweep cycle 3, then an immediate write.
        fill_all();
        idle_all();
        for (int c = 0; c < NCFG; c++) clr[c] = 1'b1;
        commit();
        for (int k = 0; k < 3; k++) begin
            idle_all();
            commit();
        end
        idle_all();
        for (int c = 0; c < NCFG; c++) begin
            rst[c] = 1'b1; ra[c] = 5'd1; rb[c] = 5'd2;
        end
        commit();
        idle_all();
        for (int c = 0; c < NCFG; c++) begin
            we0[c] = 1'b1; wa0[c] = 5'd2; wd0[c] = 16'hBEEF; ra[c] = 5'd2; rb[c] = 5'd3;
        end
        commit();
        read_all();

        // Randomized traffic with occasional clears and resets.
        for (int n = 0; n < 10000; n++) begin
            idle_all();
            for (int c = 0; c < NCFG; c++) begin
                rst[c] = ($urandom_range(0, 1999) == 0);
                clr[c] = ($urandom_range(0, 59) == 0);
                we0[c] = $urandom_range(0, 1) == 1;
                we1[c] = $urandom_range(0, 1) == 1;
                wa0[c] = 5'($urandom_range(0, nregs[c] - 1));
                wa1[c] = ($urandom_range(0, 3) == 0) ? wa0[c] : 5'($urandom_range(0, nregs[c] - 1));
                wd0[c] = 16'($urandom);
                wd1[c] = 16'($urandom);
                ra[c]  = ($urandom_range(0, 3) == 0) ? wa0[c] : 5'($urandom_range(0, nregs[c] - 1));
                rb[c]  = ($urandom_range(0, 3) == 0) ? wa1[c] : 5'($urandom_range(0, nregs[c] - 1));
            end
            commit();
        end

        idle_all();
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
